// File: rtl/fifo_packet_reader_if.sv
// Read-side FIFO port plus downstream packet port of the packet reader.
// master is the reader itself; slave is whatever sits around it.
interface fifo_packet_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 10,
  parameter int CNT_WIDTH  = 16
);
  logic                          EMPTY;
  logic [DATA_WIDTH-1:0]         RD_DATA;
  logic                          R_INC;
  logic [DATA_WIDTH*PKT_LEN-1:0] PKT_DATA;
  logic                          PKT_VALID;
  logic                          PKT_READY;
  logic                          PKT_CHK_OK;
  logic                          PKT_ERR;
  logic [CNT_WIDTH-1:0]          PKT_COUNT;

  modport master (
    input  EMPTY, RD_DATA, PKT_READY,
    output R_INC, PKT_DATA, PKT_VALID, PKT_CHK_OK, PKT_ERR, PKT_COUNT
  );

  modport slave (
    output EMPTY, RD_DATA, PKT_READY,
    input  R_INC, PKT_DATA, PKT_VALID, PKT_CHK_OK, PKT_ERR, PKT_COUNT
  );
endinterface

// File: rtl/fifo_packet_reader.sv
// Pops bytes from the async FIFO read port, assembles fixed-length packets with
// a trailing XOR checksum, and hands them downstream on a valid/ready port.
module fifo_packet_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 10,
  parameter int IDX_WIDTH  = 4,
  parameter int TIMEOUT    = 16,
  parameter int CNT_WIDTH  = 16
) (
  input logic                 R_CLK,
  input logic                 R_RST,
  fifo_packet_reader_if.master bus
);

  localparam int TO_WIDTH = $clog2(TIMEOUT + 1);
  localparam int PKT_W    = DATA_WIDTH * PKT_LEN;

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(PKT_LEN - 1);
  localparam logic [TO_WIDTH-1:0]  TO_LAST  = TO_WIDTH'(TIMEOUT - 1);

  logic [0:0]            state_q,   state_d;
  logic [IDX_WIDTH-1:0]  idx_q,     idx_d;
  logic [TO_WIDTH-1:0]   to_cnt_q,  to_cnt_d;
  logic [DATA_WIDTH-1:0] xor_q,     xor_d;
  logic [PKT_W-1:0]      pkt_q,     pkt_d;
  logic                  valid_q,   valid_d;
  logic                  chk_ok_q,  chk_ok_d;
  logic                  err_q,     err_d;
  logic [CNT_WIDTH-1:0]  count_q,   count_d;
  logic                  pop;

  // Reset gates the pop so the FIFO is never drained while we are held in reset.
  assign pop = (state_q == ST_COLLECT) && !bus.EMPTY && R_RST;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    to_cnt_d = to_cnt_q;
    xor_d    = xor_q;
    pkt_d    = pkt_q;
    valid_d  = valid_q;
    chk_ok_d = chk_ok_q;
    err_d    = 1'b0;
    count_d  = count_q;

    case (state_q)
      ST_COLLECT: begin
        if (pop) begin
          to_cnt_d = '0;
          for (int k = 0; k < PKT_LEN; k++) begin
            if (idx_q == IDX_WIDTH'(k)) begin
              pkt_d[k*DATA_WIDTH +: DATA_WIDTH] = bus.RD_DATA;
            end
          end
          if (idx_q == LAST_IDX) begin
            // Final byte is the checksum: compare, don't fold.
            chk_ok_d = (xor_q == bus.RD_DATA);
            valid_d  = 1'b1;
            idx_d    = '0;
            xor_d    = '0;
            state_d  = ST_PRESENT;
          end else begin
            xor_d = xor_q ^ bus.RD_DATA;
            idx_d = idx_q + IDX_WIDTH'(1);
          end
        end else if (idx_q != '0) begin
          // Starved mid-packet; idle gaps between packets never count.
          if (to_cnt_q == TO_LAST) begin
            idx_d    = '0;
            xor_d    = '0;
            to_cnt_d = '0;
            err_d    = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + TO_WIDTH'(1);
          end
        end
      end
      ST_PRESENT: begin
        if (bus.PKT_READY) begin
          valid_d = 1'b0;
          count_d = count_q + CNT_WIDTH'(1);
          state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      state_q  <= ST_COLLECT;
      idx_q    <= '0;
      to_cnt_q <= '0;
      xor_q    <= '0;
      pkt_q    <= '0;
      valid_q  <= 1'b0;
      chk_ok_q <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      to_cnt_q <= to_cnt_d;
      xor_q    <= xor_d;
      pkt_q    <= pkt_d;
      valid_q  <= valid_d;
      chk_ok_q <= chk_ok_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  assign bus.R_INC      = pop;
  assign bus.PKT_DATA   = pkt_q;
  assign bus.PKT_VALID  = valid_q;
  assign bus.PKT_CHK_OK = chk_ok_q;
  assign bus.PKT_ERR    = err_q;
  assign bus.PKT_COUNT  = count_q;

endmodule
